jzjpcc_decode: RTL and testbench



---
 rtl/jzjpcc_pkg.sv | 62 ++++++
 rtl/jzjpcc_immgen.sv | 19 +
 rtl/jzjpcc_decode.sv | 191 +++++++++++++++++++
 tb/tb_jzjpcc_decode.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared decode definitions for the jzjpcc RV32I core: opcodes, ALU operations and the
// decode->execute pipeline record.
package jzjpcc_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OpLui     = 7'b0110111;
    localparam opcode_t OpAuipc   = 7'b0010111;
    localparam opcode_t OpJal     = 7'b1101111;
    localparam opcode_t OpJalr    = 7'b1100111;
    localparam opcode_t OpBranch  = 7'b1100011;
    localparam opcode_t OpLoad    = 7'b0000011;
    localparam opcode_t OpStore   = 7'b0100011;
    localparam opcode_t OpOpImm   = 7'b0010011;
    localparam opcode_t OpOp      = 7'b0110011;
    localparam opcode_t OpMiscMem = 7'b0001111;
    localparam opcode_t OpSystem  = 7'b1110011;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } aluop_t;

    localparam logic [31:0] Nop = 32'h00000013;

    typedef struct packed {
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] store_data;
        aluop_t      alu_op;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_ctrl_t;

    // alt selects SUB/SRA; callers must only raise it where the encoding allows it
    function automatic aluop_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        aluop_t op;
        unique case (funct3)
            3'b000: op = alt ? AluSub : AluAdd;
            3'b001: op = AluSll;
            3'b010: op = AluSlt;
            3'b011: op = AluSltu;
            3'b100: op = AluXor;
            3'b101: op = alt ? AluSra : AluSrl;
            3'b110: op = AluOr;
            3'b111: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/jzjpcc_immgen.sv
// Combinational RV32I immediate extraction; every format is sign-extended to 32 bits.
module jzjpcc_immgen (
    input  logic [31:0] instruction,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

endmodule

// File: rtl/jzjpcc_decode.sv
// Decode stage: register-file addressing, operand muxing, control transfer resolved in
// decode, and the decode->execute pipeline register.
module jzjpcc_decode
    import jzjpcc_pkg::*;
#(
    parameter int unsigned PC_MAX_B = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instruction_decode,
    input  logic [PC_MAX_B:2]   currentPC_decode,
    output logic [4:0]          rs1Address,
    output logic [4:0]          rs2Address,
    input  logic [31:0]         rs1Data,
    input  logic [31:0]         rs2Data,
    input  logic                stall_decode,
    output logic                pcCTWriteEnable,
    output logic [PC_MAX_B:2]   controlTransferNewPC,
    output logic                flush_decode,
    output logic [31:0]         operandA_execute,
    output logic [31:0]         operandB_execute,
    output logic [31:0]         storeData_execute,
    output logic [3:0]          aluOp_execute,
    output logic [2:0]          funct3_execute,
    output logic [4:0]          rdAddress_execute,
    output logic                regWrite_execute,
    output logic                memRead_execute,
    output logic                memWrite_execute,
    output logic                illegalInstruction
);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] pc_byte, op_a, op_b, ct_target;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        illegal, ct_taken, branch_cond;
    logic        reg_write, mem_read, mem_write;
    aluop_t      alu_op;
    ex_ctrl_t    ex_d, ex_q;
    logic        illegal_q;
    logic        unused_ct_bits;

    jzjpcc_immgen u_immgen (
        .instruction (instruction_decode),
        .imm_i       (imm_i),
        .imm_s       (imm_s),
        .imm_b       (imm_b),
        .imm_u       (imm_u),
        .imm_j       (imm_j)
    );

    assign opcode     = instruction_decode[6:0];
    assign rd         = instruction_decode[11:7];
    assign funct3     = instruction_decode[14:12];
    assign funct7     = instruction_decode[31:25];
    assign rs1Address = instruction_decode[19:15];
    assign rs2Address = instruction_decode[24:20];
    assign pc_byte    = 32'({currentPC_decode, 2'b00});

    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            3'b000:  branch_cond = (rs1Data == rs2Data);
            3'b001:  branch_cond = (rs1Data != rs2Data);
            3'b100:  branch_cond = ($signed(rs1Data) <  $signed(rs2Data));
            3'b101:  branch_cond = ($signed(rs1Data) >= $signed(rs2Data));
            3'b110:  branch_cond = (rs1Data <  rs2Data);
            3'b111:  branch_cond = (rs1Data >= rs2Data);
            default: branch_cond = 1'b0;
        endcase
    end

    always_comb begin
        op_a      = rs1Data;
        op_b      = rs2Data;
        alu_op    = AluAdd;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        ct_taken  = 1'b0;
        ct_target = pc_byte + imm_b;
        case (opcode)
            OpLui: begin
                op_a      = '0;
                op_b      = imm_u;
                reg_write = 1'b1;
            end
            OpAuipc: begin
                op_a      = pc_byte;
                op_b      = imm_u;
                reg_write = 1'b1;
            end
            OpJal: begin
                op_a      = pc_byte;
                op_b      = 32'd4;
                reg_write = 1'b1;
                ct_taken  = 1'b1;
                ct_target = pc_byte + imm_j;
            end
            OpJalr: begin
                op_a      = pc_byte;
                op_b      = 32'd4;
                reg_write = 1'b1;
                ct_taken  = 1'b1;
                ct_target = (rs1Data + imm_i) & ~32'd1;
            end
            OpBranch: begin
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
                ct_taken = branch_cond;
            end
            OpLoad: begin
                op_b      = imm_i;
                reg_write = 1'b1;
                mem_read  = 1'b1;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpStore: begin
                op_b      = imm_s;
                mem_write = 1'b1;
                illegal   = (funct3 > 3'b010);
            end
            OpOpImm: begin
                op_b      = imm_i;
                reg_write = 1'b1;
                // Only shifts carry funct7; bit 30 of an ADDI immediate must not select SUB
                alu_op    = alu_from_funct3(funct3,
                                            instruction_decode[30] && (funct3 == 3'b101));
            end
            OpOp: begin
                reg_write = 1'b1;
                alu_op    = alu_from_funct3(funct3, instruction_decode[30]);
                illegal   = !((funct7 == 7'b0000000) ||
                              ((funct7 == 7'b0100000) &&
                               ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OpMiscMem, OpSystem: ;
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ct_taken  = 1'b0;
        end
        if (rd == 5'd0) reg_write = 1'b0;
    end

    assign pcCTWriteEnable      = ct_taken && !stall_decode;
    assign flush_decode         = pcCTWriteEnable;
    assign controlTransferNewPC = ct_target[PC_MAX_B:2];
    assign unused_ct_bits       = ^{ct_target[31:PC_MAX_B+1], ct_target[1:0]};

    always_comb begin
        ex_d = '0;
        if (!stall_decode) begin
            ex_d.operand_a  = op_a;
            ex_d.operand_b  = op_b;
            ex_d.store_data = rs2Data;
            ex_d.alu_op     = alu_op;
            ex_d.funct3     = funct3;
            ex_d.rd         = rd;
            ex_d.reg_write  = reg_write;
            ex_d.mem_read   = mem_read;
            ex_d.mem_write  = mem_write;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q <= ex_d;
            if (illegal) illegal_q <= 1'b1;
        end
    end

    assign operandA_execute   = ex_q.operand_a;
    assign operandB_execute   = ex_q.operand_b;
    assign storeData_execute  = ex_q.store_data;
    assign aluOp_execute      = ex_q.alu_op;
    assign funct3_execute     = ex_q.funct3;
    assign rdAddress_execute  = ex_q.rd;
    assign regWrite_execute   = ex_q.reg_write;
    assign memRead_execute    = ex_q.mem_read;
    assign memWrite_execute   = ex_q.mem_write;
    assign illegalInstruction = illegal_q;

endmodule

// File: tb/tb_jzjpcc_decode.sv
// Self-checking bench for jzjpcc_decode: table-driven vectors with a scoreboard queue for
// the execute register, plus hand-written reset, stall and illegal-instruction sequences.
module tb_jzjpcc_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction_decode;
    logic [15:2] currentPC_decode;
    logic [4:0]  rs1Address, rs2Address;
    logic [31:0] rs1Data, rs2Data;
    logic        stall_decode;
    logic        pcCTWriteEnable, flush_decode;
    logic [15:2] controlTransferNewPC;
    logic [31:0] operandA_execute, operandB_execute, storeData_execute;
    logic [3:0]  aluOp_execute;
    logic [2:0]  funct3_execute;
    logic [4:0]  rdAddress_execute;
    logic        regWrite_execute, memRead_execute, memWrite_execute;
    logic        illegalInstruction;

    int checks = 0;
    int errors = 0;

    jzjpcc_decode #(.PC_MAX_B(15)) dut (
        .clock                (clock),
        .reset                (reset),
        .instruction_decode   (instruction_decode),
        .currentPC_decode     (currentPC_decode),
        .rs1Address           (rs1Address),
        .rs2Address           (rs2Address),
        .rs1Data              (rs1Data),
        .rs2Data              (rs2Data),
        .stall_decode         (stall_decode),
        .pcCTWriteEnable      (pcCTWriteEnable),
        .controlTransferNewPC (controlTransferNewPC),
        .flush_decode         (flush_decode),
        .operandA_execute     (operandA_execute),
        .operandB_execute     (operandB_execute),
        .storeData_execute    (storeData_execute),
        .aluOp_execute        (aluOp_execute),
        .funct3_execute       (funct3_execute),
        .rdAddress_execute    (rdAddress_execute),
        .regWrite_execute     (regWrite_execute),
        .memRead_execute      (memRead_execute),
        .memWrite_execute     (memWrite_execute),
        .illegalInstruction   (illegalInstruction)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [15:2] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        stall;
        logic        ct;
        logic [15:2] tgt;
        logic        chk_ops;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   sb_idx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] instr, input logic [15:2] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic stall, input logic ct,
                       input logic [15:2] tgt, input logic chk_ops, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] sd, input logic [3:0] alu,
                       input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw);
        vec_t v;
        v = '{instr, pc, rs1, rs2, stall, ct, tgt, chk_ops, a, b, sd, alu, f3, rd, rw, mr, mw};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [15:2] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic stall);
        instruction_decode = instr;
        currentPC_decode   = pc;
        rs1Data            = rs1;
        rs2Data            = rs2;
        stall_decode       = stall;
    endtask

    task automatic compare_ex(input int idx, input vec_t e);
        check($sformatf("v%0d regWrite", idx), 32'(regWrite_execute), 32'(e.rw));
        check($sformatf("v%0d memRead", idx), 32'(memRead_execute), 32'(e.mr));
        check($sformatf("v%0d memWrite", idx), 32'(memWrite_execute), 32'(e.mw));
        if (e.chk_ops) begin
            check($sformatf("v%0d operandA", idx), operandA_execute, e.a);
            check($sformatf("v%0d operandB", idx), operandB_execute, e.b);
            check($sformatf("v%0d storeData", idx), storeData_execute, e.sd);
            check($sformatf("v%0d aluOp", idx), 32'(aluOp_execute), 32'(e.alu));
            check($sformatf("v%0d funct3", idx), 32'(funct3_execute), 32'(e.f3));
            check($sformatf("v%0d rd", idx), 32'(rdAddress_execute), 32'(e.rd));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " operandA"}, operandA_execute, 32'd0);
        check({tag, " operandB"}, operandB_execute, 32'd0);
        check({tag, " storeData"}, storeData_execute, 32'd0);
        check({tag, " aluOp"}, 32'(aluOp_execute), 32'd0);
        check({tag, " rd"}, 32'(rdAddress_execute), 32'd0);
        check({tag, " regWrite"}, 32'(regWrite_execute), 32'd0);
        check({tag, " memRead"}, 32'(memRead_execute), 32'd0);
        check({tag, " memWrite"}, 32'(memWrite_execute), 32'd0);
        check({tag, " illegal"}, 32'(illegalInstruction), 32'd0);
        check({tag, " pcCTWriteEnable"}, 32'(pcCTWriteEnable), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        drive(32'h00000013, 14'h0, 32'd0, 32'd0, 1'b0);
        #1;
        check_reset_state({tag, " in-reset"});
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_reset_state({tag, " after-nop"});
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h00000013, 14'h0, 32'd0, 32'd0, 1'b0);
        #3;
        check_reset_state("por");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        //   instr         pc      rs1           rs2           st ct tgt     chk a             b             sd            alu  f3 rd  rw mr mw
        add(32'h00700293, 14'h40, 32'h0,        32'h55,       0, 0, 14'h0,  1, 32'h0,        32'h7,        32'h55,       4'd0, 0, 5,  1, 0, 0);
        add(32'h00000013, 14'h40, 32'h0,        32'h0,        0, 0, 14'h0,  1, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h123451B7, 14'h40, 32'h99,       32'h0,        0, 0, 14'h0,  1, 32'h0,        32'h12345000, 32'h0,        4'd0, 5, 3,  1, 0, 0);
        add(32'h00001397, 14'h40, 32'h0,        32'h0,        0, 0, 14'h0,  1, 32'h100,      32'h1000,     32'h0,        4'd0, 1, 7,  1, 0, 0);
        add(32'h00208333, 14'h40, 32'h11,       32'h22,       0, 0, 14'h0,  1, 32'h11,       32'h22,       32'h22,       4'd0, 0, 6,  1, 0, 0);
        add(32'h40208333, 14'h40, 32'h11,       32'h22,       0, 0, 14'h0,  1, 32'h11,       32'h22,       32'h22,       4'd1, 0, 6,  1, 0, 0);
        add(32'h4030D413, 14'h40, 32'h80000000, 32'h0,        0, 0, 14'h0,  1, 32'h80000000, 32'h403,      32'h0,        4'd7, 5, 8,  1, 0, 0);
        add(32'hFFF0B493, 14'h40, 32'h5,        32'h0,        0, 0, 14'h0,  1, 32'h5,        32'hFFFFFFFF, 32'h0,        4'd4, 3, 9,  1, 0, 0);
        add(32'hC0008513, 14'h40, 32'h5,        32'h0,        0, 0, 14'h0,  1, 32'h5,        32'hFFFFFC00, 32'h0,        4'd0, 0, 10, 1, 0, 0);
        add(32'h0020A623, 14'h40, 32'h1000,     32'hDEADBEEF, 0, 0, 14'h0,  1, 32'h1000,     32'hC,        32'hDEADBEEF, 4'd0, 2, 12, 0, 0, 1);
        add(32'hFFC0A203, 14'h40, 32'h1000,     32'h7,        0, 0, 14'h0,  1, 32'h1000,     32'hFFFFFFFC, 32'h7,        4'd0, 2, 4,  1, 1, 0);
        add(32'h00208863, 14'h40, 32'h3,        32'h3,        0, 1, 14'h44, 0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h00208863, 14'h40, 32'h3,        32'h4,        0, 0, 14'h0,  0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h00209863, 14'h40, 32'h3,        32'h4,        0, 1, 14'h44, 0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h0020C863, 14'h40, 32'hFFFFFFFF, 32'h1,        0, 1, 14'h44, 0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h0020E863, 14'h40, 32'hFFFFFFFF, 32'h1,        0, 0, 14'h0,  0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h0020D863, 14'h40, 32'h1,        32'hFFFFFFFF, 0, 1, 14'h44, 0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h0020F863, 14'h40, 32'h1,        32'hFFFFFFFF, 0, 0, 14'h0,  0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'hFE000EE3, 14'h0,  32'h0,        32'h0,        0, 1, 14'h3FFF, 0, 32'h0,      32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h008000EF, 14'h40, 32'h0,        32'h0,        0, 1, 14'h42, 1, 32'h100,      32'h4,        32'h0,        4'd0, 0, 1,  1, 0, 0);
        add(32'h008180E7, 14'h40, 32'h203,      32'h0,        0, 1, 14'h82, 1, 32'h100,      32'h4,        32'h0,        4'd0, 0, 1,  1, 0, 0);
        add(32'h008000EF, 14'h40, 32'h0,        32'h0,        1, 0, 14'h0,  1, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h00208863, 14'h40, 32'h3,        32'h3,        1, 0, 14'h0,  1, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h00000073, 14'h40, 32'h0,        32'h0,        0, 0, 14'h0,  0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);
        add(32'h0FF0000F, 14'h40, 32'h0,        32'h0,        0, 0, 14'h0,  0, 32'h0,        32'h0,        32'h0,        4'd0, 0, 0,  0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            int   idx;
            v = vecs[i];
            @(negedge clock);
            drive(v.instr, v.pc, v.rs1, v.rs2, v.stall);
            #1;
            check($sformatf("v%0d rs1Address", i), 32'(rs1Address), 32'(v.instr[19:15]));
            check($sformatf("v%0d rs2Address", i), 32'(rs2Address), 32'(v.instr[24:20]));
            check($sformatf("v%0d pcCTWriteEnable", i), 32'(pcCTWriteEnable), 32'(v.ct));
            check($sformatf("v%0d flush_decode", i), 32'(flush_decode), 32'(v.ct));
            if (v.ct) check($sformatf("v%0d target", i), 32'(controlTransferNewPC), 32'(v.tgt));
            sb.push_back(v);
            sb_idx.push_back(i);
            @(posedge clock);
            #1;
            v   = sb.pop_front();
            idx = sb_idx.pop_front();
            compare_ex(idx, v);
        end
        check("legal-run illegal", 32'(illegalInstruction), 32'd0);

        // OP with an M-extension funct7 must decode as a nop and raise the sticky flag
        @(negedge clock);
        drive(32'h02208333, 14'h40, 32'h11, 32'h22, 1'b0);
        @(posedge clock);
        #1;
        check("badf7 regWrite", 32'(regWrite_execute), 32'd0);
        check("badf7 illegal", 32'(illegalInstruction), 32'd1);

        pulse_reset("reset1");

        // Branch funct3 010 with equal operands: no transfer even though beq would be taken
        @(negedge clock);
        drive(32'h0020A863, 14'h40, 32'h3, 32'h3, 1'b0);
        #1;
        check("br010 pcCTWriteEnable", 32'(pcCTWriteEnable), 32'd0);
        check("br010 flush_decode", 32'(flush_decode), 32'd0);
        @(posedge clock);
        #1;
        check("br010 illegal", 32'(illegalInstruction), 32'd1);

        pulse_reset("reset2");

        @(negedge clock);
        drive(32'hFFFFFFFF, 14'h40, 32'h1, 32'h2, 1'b0);
        #1;
        check("ones pcCTWriteEnable", 32'(pcCTWriteEnable), 32'd0);
        @(posedge clock);
        #1;
        check("ones regWrite", 32'(regWrite_execute), 32'd0);
        check("ones memRead", 32'(memRead_execute), 32'd0);
        check("ones memWrite", 32'(memWrite_execute), 32'd0);
        check("ones illegal", 32'(illegalInstruction), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(32'h00700293, 14'h40, 32'h0, 32'h0, 1'b0);
            @(posedge clock);
            #1;
            check($sformatf("sticky%0d illegal", k), 32'(illegalInstruction), 32'd1);
            check($sformatf("sticky%0d regWrite", k), 32'(regWrite_execute), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
